// File: rtl/bcd_calc_pkg.sv
// Shared types, constants and the BCD add helper for the two-digit BCD
// adder controller.
package bcd_calc_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    ADD     = 3'd2,
    SHOW    = 3'd3,
    ERR     = 3'd4
  } state_t;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [4:0] BCD_ADJ   = 5'd6;
  localparam logic [3:0] ERR_DIGIT = 4'hF;

  // Adds two valid BCD digits; returns {tens, units}. Results stay in 00..18.
  function automatic logic [7:0] bcd_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum_s;
    logic [4:0] adj_s;
    sum_s = {1'b0, a} + {1'b0, b};
    adj_s = sum_s + BCD_ADJ;
    if (sum_s > {1'b0, BCD_MAX}) begin
      bcd_add = {4'd1, adj_s[3:0]};
    end else begin
      bcd_add = {4'd0, sum_s[3:0]};
    end
  endfunction

  // One-hot LED pattern for a state: [0]=ENTER_A .. [4]=ERR
  function automatic logic [4:0] state_led(input state_t s);
    case (s)
      ENTER_A: state_led = 5'b00001;
      ENTER_B: state_led = 5'b00010;
      ADD:     state_led = 5'b00100;
      SHOW:    state_led = 5'b01000;
      ERR:     state_led = 5'b10000;
      default: state_led = 5'b10000;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// ENTER conditioning: 2-FF synchronizer, stable-level debouncer and a
// rising-edge detector producing a registered one-cycle press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic ENTER,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;
  logic             db_r;
  logic             db_prev_r;
  logic             press_r;

  // Bring the asynchronous button level into the clock domain
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= ENTER;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only after it has been stable long enough
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      cnt_r <= CNT_ZERO;
      db_r  <= 1'b0;
    end else if (sync2_r != db_r) begin
      if (cnt_r == CNT_LAST) begin
        db_r  <= sync2_r;
        cnt_r <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end else begin
      cnt_r <= CNT_ZERO;
    end
  end

  // Registered pulse on a debounced rising edge only
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      db_prev_r <= 1'b0;
      press_r   <= 1'b0;
    end else begin
      db_prev_r <= db_r;
      press_r   <= db_r & ~db_prev_r;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/bcd_add_ctrl.sv
// Sequencing controller for the two-digit BCD adder: operand entry with
// validation, one-cycle add, result display and error display.
module bcd_add_ctrl
  import bcd_calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [3:0] SW,
  input  logic       ENTER,
  output logic [3:0] DIGIT1,
  output logic [3:0] DIGIT0,
  output logic [4:0] LEDR
);

  logic       press_s;
  state_t     state_r;
  logic [3:0] a_r;
  logic [3:0] b_r;
  logic [7:0] result_r;
  logic [3:0] digit1_r;
  logic [3:0] digit0_r;
  logic [4:0] led_r;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .CLOCK_50(CLOCK_50),
    .RESET   (RESET),
    .ENTER   (ENTER),
    .press   (press_s)
  );

  // FSM with operand/result registers; outputs are set for the next state
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_r  <= ENTER_A;
      a_r      <= 4'd0;
      b_r      <= 4'd0;
      result_r <= 8'd0;
      digit1_r <= 4'd0;
      digit0_r <= 4'd0;
      led_r    <= state_led(ENTER_A);
    end else begin
      case (state_r)
        ENTER_A: begin
          if (press_s && (SW <= BCD_MAX)) begin
            a_r      <= SW;
            state_r  <= ENTER_B;
            led_r    <= state_led(ENTER_B);
            digit1_r <= 4'd0;
            digit0_r <= SW;
          end else if (press_s) begin
            state_r  <= ERR;
            led_r    <= state_led(ERR);
            digit1_r <= ERR_DIGIT;
            digit0_r <= ERR_DIGIT;
          end else begin
            digit1_r <= 4'd0;
            digit0_r <= SW;
          end
        end
        ENTER_B: begin
          if (press_s && (SW <= BCD_MAX)) begin
            b_r      <= SW;
            state_r  <= ADD;
            led_r    <= state_led(ADD);
            digit1_r <= result_r[7:4];
            digit0_r <= result_r[3:0];
          end else if (press_s) begin
            state_r  <= ERR;
            led_r    <= state_led(ERR);
            digit1_r <= ERR_DIGIT;
            digit0_r <= ERR_DIGIT;
          end else begin
            digit1_r <= 4'd0;
            digit0_r <= SW;
          end
        end
        ADD: begin
          // Presses landing here are dropped; ADD lasts a single cycle
          result_r <= bcd_add(a_r, b_r);
          {digit1_r, digit0_r} <= bcd_add(a_r, b_r);
          state_r  <= SHOW;
          led_r    <= state_led(SHOW);
        end
        SHOW: begin
          if (press_s) begin
            a_r      <= 4'd0;
            b_r      <= 4'd0;
            result_r <= 8'd0;
            state_r  <= ENTER_A;
            led_r    <= state_led(ENTER_A);
            digit1_r <= 4'd0;
            digit0_r <= SW;
          end else begin
            digit1_r <= result_r[7:4];
            digit0_r <= result_r[3:0];
          end
        end
        ERR: begin
          if (press_s) begin
            a_r      <= 4'd0;
            b_r      <= 4'd0;
            state_r  <= ENTER_A;
            led_r    <= state_led(ENTER_A);
            digit1_r <= 4'd0;
            digit0_r <= SW;
          end else begin
            digit1_r <= ERR_DIGIT;
            digit0_r <= ERR_DIGIT;
          end
        end
        default: begin
          // Unreachable encodings recover to a clean entry state
          state_r  <= ENTER_A;
          a_r      <= 4'd0;
          b_r      <= 4'd0;
          result_r <= 8'd0;
          digit1_r <= 4'd0;
          digit0_r <= 4'd0;
          led_r    <= state_led(ENTER_A);
        end
      endcase
    end
  end

  assign DIGIT1 = digit1_r;
  assign DIGIT0 = digit0_r;
  assign LEDR   = led_r;

endmodule

// File: tb/tb_bcd_add_ctrl.sv
// Directed bench for bcd_add_ctrl with DEBOUNCE_CYCLES=4: table-driven
// operand/result vectors plus hand sequences for latency, bounce and reset.
module tb_bcd_add_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic       enter;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic [4:0] ledr;

  int checks = 0;
  int errors = 0;
  int press_cnt = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d1;
    logic [3:0] d0;
  } vec_t;

  vec_t vecs[8];

  bcd_add_ctrl #(.DEBOUNCE_CYCLES(4)) u_dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .SW      (sw),
    .ENTER   (enter),
    .DIGIT1  (digit1),
    .DIGIT0  (digit0),
    .LEDR    (ledr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count debounced press pulses
  always @(posedge clk) begin
    if (u_dut.press_s) press_cnt <= press_cnt + 1;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Clean press: hold long enough to debounce, then release and settle
  task automatic press_button();
    enter = 1'b1;
    repeat (12) @(negedge clk);
    enter = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // Raise ENTER and count cycles until the press pulse (bounded)
  task automatic rise_and_measure(output int cyc);
    cyc = -1;
    enter = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (u_dut.press_s && cyc < 0) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int base;

    vecs[0] = '{a: 4'd3,  b: 4'd4,  d1: 4'd0, d0: 4'd7};
    vecs[1] = '{a: 4'd9,  b: 4'd8,  d1: 4'd1, d0: 4'd7};
    vecs[2] = '{a: 4'd5,  b: 4'd5,  d1: 4'd1, d0: 4'd0};
    vecs[3] = '{a: 4'd0,  b: 4'd0,  d1: 4'd0, d0: 4'd0};
    vecs[4] = '{a: 4'd9,  b: 4'd9,  d1: 4'd1, d0: 4'd8};
    vecs[5] = '{a: 4'd1,  b: 4'd8,  d1: 4'd0, d0: 4'd9};
    vecs[6] = '{a: 4'd12, b: 4'd0,  d1: 4'hF, d0: 4'hF};
    vecs[7] = '{a: 4'd7,  b: 4'd15, d1: 4'hF, d0: 4'hF};

    rst = 1'b1;
    sw = 4'd0;
    enter = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_led", 8'(ledr), 8'h01);
    check("reset_d1", 8'(digit1), 8'h00);
    check("reset_d0", 8'(digit0), 8'h00);
    check("reset_press", 8'(u_dut.press_s), 8'h00);
    rst = 1'b0;

    // Live SW display in ENTER_A
    sw = 4'd5;
    repeat (2) @(negedge clk);
    check("live_sw_a", 8'(digit0), 8'h05);

    // Table of operand pairs
    for (int i = 0; i < 8; i++) begin
      sw = vecs[i].a;
      press_button();
      if (vecs[i].a > 4'd9) begin
        check("err_a_led", 8'(ledr), 8'h10);
        check("err_a_dig", {digit1, digit0}, {vecs[i].d1, vecs[i].d0});
        press_button();
        check("err_a_back", 8'(ledr), 8'h01);
        continue;
      end
      check("enter_b_led", 8'(ledr), 8'h02);
      check("enter_b_d0", 8'(digit0), 8'(vecs[i].a));
      sw = vecs[i].b;
      press_button();
      if (vecs[i].b > 4'd9) begin
        check("err_b_led", 8'(ledr), 8'h10);
        check("err_b_dig", {digit1, digit0}, {vecs[i].d1, vecs[i].d0});
        press_button();
        check("err_b_back", 8'(ledr), 8'h01);
        continue;
      end
      check("show_led", 8'(ledr), 8'h08);
      check("show_dig", {digit1, digit0}, {vecs[i].d1, vecs[i].d0});
      sw = 4'd6;
      repeat (2) @(negedge clk);
      check("show_ignores_sw", {digit1, digit0}, {vecs[i].d1, vecs[i].d0});
      press_button();
      check("back_led", 8'(ledr), 8'h01);
      check("back_d0", {digit1, digit0}, 8'h06);
    end

    // Press latency and ADD -> SHOW timing (A=4, B=5)
    sw = 4'd4;
    press_button();
    sw = 4'd5;
    rise_and_measure(cyc);
    check("press_latency", 8'(cyc), 8'd7);
    @(negedge clk);
    check("add_state_led", 8'(ledr), 8'h04);
    @(negedge clk);
    check("show_timing_led", 8'(ledr), 8'h08);
    check("show_timing_dig", {digit1, digit0}, 8'h09);
    enter = 1'b0;
    repeat (12) @(negedge clk);
    press_button();
    check("latency_back", 8'(ledr), 8'h01);

    // Bounce rejection: toggle every 2 cycles for 20 cycles, then hold high
    sw = 4'd1;
    base = press_cnt;
    for (int t = 0; t < 10; t++) begin
      enter = ~enter;
      repeat (2) @(negedge clk);
    end
    check("bounce_no_pulse", 8'(press_cnt - base), 8'd0);
    rise_and_measure(cyc);
    check("bounce_latency", 8'(cyc), 8'd7);
    repeat (100) @(negedge clk);
    check("hold_one_pulse", 8'(press_cnt - base), 8'd1);
    enter = 1'b0;
    repeat (20) @(negedge clk);
    check("release_no_pulse", 8'(press_cnt - base), 8'd1);
    check("bounce_state", 8'(ledr), 8'h02);

    // Invalid then back, then A=6 and reset in ENTER_B
    sw = 4'd11;
    press_button();
    check("err_via_b", 8'(ledr), 8'h10);
    press_button();
    sw = 4'd6;
    press_button();
    check("pre_reset_led", 8'(ledr), 8'h02);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_led", 8'(ledr), 8'h01);
    check("async_rst_dig", {digit1, digit0}, 8'h00);
    check("async_rst_a", 8'(u_dut.a_r), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    sw = 4'd2;
    press_button();
    press_button();
    check("post_rst_led", 8'(ledr), 8'h08);
    check("post_rst_dig", {digit1, digit0}, 8'h04);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
